pwm_multi_channel: RTL and testbench

Parameterised successor to the single-channel PWM generator. It provides NUM_CH independent PWM outputs sharing one period counter, with double-buffered (glitch-free) duty updates and edge- or center-aligned modes. It also provides a divided clock output and a period-start strobe. It sits between the control register block and the motor/LED drivers, clocked from clk_1MHz.

---
 rtl/pwm_multi_channel.sv | 117 +++++++++++
 tb/tb_pwm_multi_channel.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: NUM_CH PWM outputs sharing one period counter, with
// double-buffered duties, edge/center alignment, a period-start strobe and a
// free-running clock divider.
//
// Ports:
//   clk_1MHz     in   sole clock, all logic on the rising edge
//   rst_n        in   synchronous reset, active-low
//   duty_in      in   packed duties, channel i at [i*DUTY_W +: DUTY_W]
//   duty_load    in   capture duty_in into the pending registers
//   center_mode  in   0 = edge-aligned, 1 = center-aligned (taken at a boundary)
//   ch_en        in   per-channel enable, takes effect immediately
//   pwm_out      out  registered PWM outputs
//   duty_ack     out  one-cycle pulse when pending duties become active
//   period_start out  one-cycle pulse in the output cycle of cnt = 0
//   clk_div_out  out  divided clock, CLK_DIV cycles per level
module pwm_multi_channel #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 11,
    parameter int DUTY_W  = 11,
    parameter int PERIOD  = 2000,
    parameter int CLK_DIV = 1000
) (
    input  logic                     clk_1MHz,
    input  logic                     rst_n,
    input  logic [NUM_CH*DUTY_W-1:0] duty_in,
    input  logic                     duty_load,
    input  logic                     center_mode,
    input  logic [NUM_CH-1:0]        ch_en,
    output logic [NUM_CH-1:0]        pwm_out,
    output logic                     duty_ack,
    output logic                     period_start,
    output logic                     clk_div_out
);
    localparam logic [CNT_W-1:0] TOP  = CNT_W'(PERIOD - 1);
    // First value of the descending ramp; with PERIOD = 2 there is no ramp.
    localparam logic [CNT_W-1:0] TURN = CNT_W'(PERIOD > 2 ? PERIOD - 2 : 0);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic                     dir_down;
    logic                     dir_nxt;
    logic                     mode;
    logic                     after_rst;
    logic                     pend;
    logic                     at_top;
    logic                     boundary;
    logic [NUM_CH*DUTY_W-1:0] active;
    logic [NUM_CH*DUTY_W-1:0] pending;
    logic [NUM_CH-1:0]        raw;
    logic [DIV_W-1:0]         div_cnt;

    // Center mode ramps 0..TOP, then TURN..1; the step out of 1 (or out of TOP
    // in edge mode) lands on 0 and marks the period boundary.
    always_comb begin
        at_top   = cnt == TOP;
        cnt_nxt  = !mode ? (at_top ? '0 : cnt + 1'b1)
                 : dir_down ? cnt - 1'b1
                 : at_top ? TURN : cnt + 1'b1;
        dir_nxt  = mode && (cnt_nxt != '0) && (dir_down || at_top);
        boundary = after_rst || (cnt_nxt == '0);
    end

    // Duty 0 compares false at cnt = 0, so there is no forced-high glitch;
    // duty >= PERIOD compares true for every counter value.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign raw[i] = ch_en[i] && (DUTY_W'(cnt) < active[i*DUTY_W +: DUTY_W]);
    end

    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            cnt          <= '0;
            dir_down     <= 1'b0;
            mode         <= 1'b0;
            after_rst    <= 1'b1;
            pend         <= 1'b0;
            active       <= '0;
            pending      <= '0;
            pwm_out      <= '0;
            duty_ack     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            dir_down     <= dir_nxt;
            after_rst    <= 1'b0;
            pwm_out      <= raw;
            period_start <= cnt == '0;
            duty_ack     <= boundary && (pend || duty_load);
            if (duty_load)
                pending <= duty_in;
            if (boundary) begin
                mode <= center_mode;
                pend <= 1'b0;
                // A load coinciding with the boundary bypasses the shadow.
                if (duty_load)
                    active <= duty_in;
                else if (pend)
                    active <= pending;
            end else if (duty_load) begin
                pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            clk_div_out <= 1'b0;
        end else if (div_cnt == DIV_TOP) begin
            div_cnt     <= '0;
            clk_div_out <= ~clk_div_out;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed, table-driven checks of pwm_multi_channel.
`timescale 1ns/1ps
module tb_pwm_multi_channel;
    localparam int NUM_CH = 4;
    localparam int DUTY_W = 11;
    localparam int DW     = NUM_CH * DUTY_W;

    logic              clk_1MHz = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     duty_in = '0;
    logic              duty_load = 1'b0;
    logic              center_mode = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic [NUM_CH-1:0] pwm_out;
    logic              duty_ack;
    logic              period_start;
    logic              clk_div_out;

    int n_cmp = 0;
    int n_bad = 0;
    int len;
    int acks;
    int hi[NUM_CH];

    typedef struct {
        logic [DW-1:0]           duty;
        logic [NUM_CH-1:0]       en;
        logic                    center;
        int                      len;
        logic [NUM_CH-1:0][15:0] hi;
        logic [NUM_CH-1:0]       first;
    } vec_t;

    always #5 clk_1MHz = ~clk_1MHz;

    pwm_multi_channel dut (
        .clk_1MHz    (clk_1MHz),
        .rst_n       (rst_n),
        .duty_in     (duty_in),
        .duty_load   (duty_load),
        .center_mode (center_mode),
        .ch_en       (ch_en),
        .pwm_out     (pwm_out),
        .duty_ack    (duty_ack),
        .period_start(period_start),
        .clk_div_out (clk_div_out)
    );

    function automatic logic [DW-1:0] pack(input logic [10:0] d3, input logic [10:0] d2,
                                           input logic [10:0] d1, input logic [10:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Starts on a negedge where period_start is 1 and stops at the next one,
    // counting cycles, high cycles per channel and duty_ack pulses. Optional
    // one-cycle loads are issued at cycle offsets la and lb.
    task automatic run_period(input int la, input logic [DW-1:0] da,
                              input int lb, input logic [DW-1:0] db);
        len  = 0;
        acks = 0;
        hi   = '{default: 0};
        do begin
            for (int c = 0; c < NUM_CH; c++) hi[c] += int'(pwm_out[c]);
            acks += int'(duty_ack);
            if (len == la) begin
                duty_in   = da;
                duty_load = 1'b1;
            end else if (len == lb) begin
                duty_in   = db;
                duty_load = 1'b1;
            end else begin
                duty_load = 1'b0;
            end
            @(negedge clk_1MHz);
            len++;
        end while (!period_start && len < 9000);
        duty_load = 1'b0;
    endtask

    task automatic do_vec(input int id, input vec_t v);
        int n;
        duty_in     = v.duty;
        ch_en       = v.en;
        center_mode = v.center;
        duty_load   = 1'b1;
        @(negedge clk_1MHz);
        duty_load = 1'b0;
        n = 0;
        while (!duty_ack && n < 9000) begin
            @(negedge clk_1MHz);
            n++;
        end
        chk($sformatf("v%0d_ack", id), int'(duty_ack), 1);
        @(negedge clk_1MHz);
        chk($sformatf("v%0d_ps_after_ack", id), int'(period_start), 1);
        chk($sformatf("v%0d_first", id), int'(pwm_out), int'(v.first));
        run_period(-1, '0, -1, '0);
        chk($sformatf("v%0d_len", id), len, v.len);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("v%0d_hi%0d", id, c), hi[c], int'(v.hi[c]));
    endtask

    initial begin
        vec_t vecs[6];
        int   n;
        vecs[0] = '{duty: pack(0, 0, 0, 400), en: 4'b0001, center: 1'b0, len: 2000,
                    hi: {16'd0, 16'd0, 16'd0, 16'd400}, first: 4'b0001};
        vecs[1] = '{duty: pack(1, 2047, 2000, 0), en: 4'b1111, center: 1'b0, len: 2000,
                    hi: {16'd1, 16'd2000, 16'd2000, 16'd0}, first: 4'b1110};
        vecs[2] = '{duty: pack(1, 2047, 2000, 0), en: 4'b0101, center: 1'b0, len: 2000,
                    hi: {16'd0, 16'd2000, 16'd0, 16'd0}, first: 4'b0100};
        vecs[3] = '{duty: pack(0, 0, 0, 500), en: 4'b0001, center: 1'b1, len: 3998,
                    hi: {16'd0, 16'd0, 16'd0, 16'd999}, first: 4'b0001};
        vecs[4] = '{duty: pack(0, 1, 1999, 2000), en: 4'b1111, center: 1'b1, len: 3998,
                    hi: {16'd0, 16'd1, 16'd3997, 16'd3998}, first: 4'b0111};
        vecs[5] = '{duty: pack(2, 1000, 2000, 1999), en: 4'b1111, center: 1'b0, len: 2000,
                    hi: {16'd2, 16'd1000, 16'd2000, 16'd1999}, first: 4'b1111};

        repeat (3) @(negedge clk_1MHz);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_ack", int'(duty_ack), 0);
        chk("rst_ps", int'(period_start), 0);
        chk("rst_div", int'(clk_div_out), 0);

        // Free run: divider level changes exactly every 1000 cycles after release.
        rst_n = 1'b1;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk_1MHz);
            if (k % 1000 == 0 || k % 1000 == 999)
                chk($sformatf("div_k%0d", k), int'(clk_div_out), (k / 1000) % 2);
            if (k == 1 || k == 2000 || k == 2001 || k == 4001)
                chk($sformatf("ps_k%0d", k), int'(period_start), int'(k % 2000 == 1));
        end
        chk("idle_pwm", int'(pwm_out), 0);

        for (int i = 0; i < 6; i++) do_vec(i, vecs[i]);

        // Mode request is held off until the end of the running period.
        center_mode = 1'b1;
        run_period(-1, '0, -1, '0);
        chk("mode_on_len_old", len, 2000);
        run_period(-1, '0, -1, '0);
        chk("mode_on_len_new", len, 3998);
        chk("mode_on_hi1", hi[1], 3998);
        center_mode = 1'b0;
        run_period(-1, '0, -1, '0);
        chk("mode_off_len_old", len, 3998);
        run_period(-1, '0, -1, '0);
        chk("mode_off_len_new", len, 2000);

        // Disable mid-period: output drops next cycle, counter keeps its phase.
        repeat (100) @(negedge clk_1MHz);
        chk("en_before", int'(pwm_out[1]), 1);
        ch_en = 4'b1101;
        @(negedge clk_1MHz);
        chk("en_off_ch1", int'(pwm_out[1]), 0);
        chk("en_off_ch0", int'(pwm_out[0]), 1);
        n = 0;
        while (!period_start && n < 5000) begin
            @(negedge clk_1MHz);
            n++;
        end
        chk("en_ps_dist", n, 1899);

        // Two loads in one period: old duty holds, one ack, last load wins.
        do_vec(6, vecs[0]);
        run_period(499, pack(0, 0, 0, 1500), 899, pack(0, 0, 0, 1200));
        chk("dbl_hi_old", hi[0], 400);
        chk("dbl_acks", acks, 1);
        chk("dbl_len", len, 2000);
        run_period(-1, '0, -1, '0);
        chk("dbl_hi_new", hi[0], 1200);
        chk("dbl_acks_after", acks, 0);

        // Reset at cnt = 1234 clears outputs and active duties.
        ch_en = 4'b1111;
        repeat (1233) @(negedge clk_1MHz);
        rst_n = 1'b0;
        @(negedge clk_1MHz);
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_ack", int'(duty_ack), 0);
        chk("mid_rst_ps", int'(period_start), 0);
        chk("mid_rst_div", int'(clk_div_out), 0);
        rst_n = 1'b1;
        @(negedge clk_1MHz);
        chk("post_rst_ps", int'(period_start), 1);
        chk("post_rst_pwm", int'(pwm_out), 0);
        run_period(-1, '0, -1, '0);
        chk("post_rst_len", len, 2000);
        chk("post_rst_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
